fetch_sequencer: RTL and testbench

- Parametrised successor to the single-purpose Mealy control matrix. Drives PC, MAR, IR and the memory-read strobe through a configurable reset sequence, a reset-vector load and a repeating fetch cycle with a ready handshake, halt request and timeout fault.
- Sits between the datapath (PC mux, PC, MAR mux, MAR, IR) and the memory interface. Register-control outputs are active-low.
- Mealy: some outputs depend on the current state and the current inputs in the same cycle.

---
 rtl/cpu_ctrl_pkg.sv | 32 +++
 rtl/fetch_sequencer_if.sv | 37 +++
 rtl/seq_counter.sv | 29 ++
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl_pkg : state encoding and mux select codes for the sequencer  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_RESET      = 3'd0,
    S_VECTOR     = 3'd1,
    S_FETCH_ADDR = 3'd2,
    S_FETCH_MEM  = 3'd3,
    S_DECODE     = 3'd4,
    S_HALT       = 3'd5,
    S_FAULT      = 3'd6
  } state_e;

  // Select codes shared with the PC and MAR mux instances in the datapath.
  localparam int PC_SRC_SEL_HOLD   = 0;
  localparam int PC_SRC_SEL_VECTOR = 2;
  localparam int ADDR_SRC_SEL_PC   = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer_if : control bus between sequencer and datapath/mem   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface fetch_sequencer_if #(
  parameter int PC_SELECT_SIZE   = 3,
  parameter int ADDR_SELECT_SIZE = 2
);
  logic                        halt_req_i;
  logic                        mem_ready_i;
  logic                        pc_rst_no;
  logic                        pc_ld_no;
  logic                        pc_inc_no;
  logic                        mar_rst_no;
  logic                        mar_ld_no;
  logic                        ir_ld_no;
  logic                        mem_rd_o;
  logic [PC_SELECT_SIZE-1:0]   pc_src_o;
  logic [ADDR_SELECT_SIZE-1:0] addr_src_o;
  logic                        halted_o;
  logic                        fault_o;
  logic [2:0]                  state_o;

  modport master (
    input  halt_req_i, mem_ready_i,
    output pc_rst_no, pc_ld_no, pc_inc_no, mar_rst_no, mar_ld_no, ir_ld_no,
           mem_rd_o, pc_src_o, addr_src_o, halted_o, fault_o, state_o
  );

  modport slave (
    output halt_req_i, mem_ready_i,
    input  pc_rst_no, pc_ld_no, pc_inc_no, mar_rst_no, mar_ld_no, ir_ld_no,
           mem_rd_o, pc_src_o, addr_src_o, halted_o, fault_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_counter : synchronous clear/enable up-counter, clear has priority |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module seq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)   count_d = '0;
    else if (en_i) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer : Mealy reset/vector/fetch control for PC, MAR and IR |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_SELECT_SIZE   = 3,
  parameter int ADDR_SELECT_SIZE = 2,
  parameter int RESET_CYCLES     = 3,
  parameter int PC_SRC_VECTOR    = PC_SRC_SEL_VECTOR,
  parameter int ADDR_SRC_PC      = ADDR_SRC_SEL_PC,
  parameter int READY_TIMEOUT    = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  fetch_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(max3(RESET_CYCLES, READY_TIMEOUT, 2));

  localparam logic [CNT_W-1:0]            c_rst_last = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]            c_to_last  = CNT_W'(READY_TIMEOUT - 1);
  localparam bit                          c_to_en    = (READY_TIMEOUT != 0);
  localparam logic [PC_SELECT_SIZE-1:0]   c_pc_vec   = PC_SELECT_SIZE'(PC_SRC_VECTOR);
  localparam logic [PC_SELECT_SIZE-1:0]   c_pc_hold  = PC_SELECT_SIZE'(PC_SRC_SEL_HOLD);
  localparam logic [ADDR_SELECT_SIZE-1:0] c_addr_pc  = ADDR_SELECT_SIZE'(ADDR_SRC_PC);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  // One counter serves both the reset hold and the ready timeout; it is
  // cleared whenever the state changes so each use starts from zero.
  seq_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk_i   (clk_i),
    .clear_i (w_cnt_clr),
    .en_i    (w_cnt_en),
    .count_o (cnt_q)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_RESET;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    w_cnt_en = 1'b0;
    case (state_q)
      S_RESET: begin
        if (cnt_q == c_rst_last) state_d  = S_VECTOR;
        else                     w_cnt_en = 1'b1;
      end
      S_VECTOR:     state_d = S_FETCH_ADDR;
      S_FETCH_ADDR: state_d = S_FETCH_MEM;
      S_FETCH_MEM: begin
        if (bus.mem_ready_i)                      state_d  = S_DECODE;
        else if (c_to_en && (cnt_q == c_to_last)) state_d  = S_FAULT;
        else                                      w_cnt_en = 1'b1;
      end
      S_DECODE:     state_d = bus.halt_req_i ? S_HALT : S_FETCH_ADDR;
      S_HALT:       state_d = S_HALT;
      S_FAULT:      state_d = S_FAULT;
      default:      state_d = S_RESET;
    endcase
    w_cnt_clr = reset_i || (state_d != state_q);
  end

  always_comb begin
    bus.pc_rst_no  = 1'b1;
    bus.pc_ld_no   = 1'b1;
    bus.pc_inc_no  = 1'b1;
    bus.mar_rst_no = 1'b1;
    bus.mar_ld_no  = 1'b1;
    bus.ir_ld_no   = 1'b1;
    bus.mem_rd_o   = 1'b0;
    bus.pc_src_o   = c_pc_hold;
    bus.addr_src_o = '0;
    bus.halted_o   = 1'b0;
    bus.fault_o    = 1'b0;
    case (state_q)
      S_RESET: begin
        bus.pc_rst_no  = 1'b0;
        bus.mar_rst_no = 1'b0;
      end
      S_VECTOR: begin
        bus.pc_src_o = c_pc_vec;
        bus.pc_ld_no = 1'b0;
      end
      S_FETCH_ADDR: begin
        bus.addr_src_o = c_addr_pc;
        bus.mar_ld_no  = 1'b0;
      end
      S_FETCH_MEM: begin
        bus.mem_rd_o = 1'b1;
        if (bus.mem_ready_i) begin
          bus.ir_ld_no  = 1'b0;
          bus.pc_inc_no = 1'b0;
        end
      end
      S_HALT:  bus.halted_o = 1'b1;
      S_FAULT: bus.fault_o  = 1'b1;
      default: ;
    endcase
  end

  assign bus.state_o = state_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_sequencer : vector table + scoreboard bench for the sequencer|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_sequencer;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b1;
  logic halt = 1'b0;
  logic rdy  = 1'b0;

  fetch_sequencer_if #(.PC_SELECT_SIZE(3), .ADDR_SELECT_SIZE(2)) bus ();
  fetch_sequencer_if #(.PC_SELECT_SIZE(3), .ADDR_SELECT_SIZE(2)) bus0 ();

  assign bus.halt_req_i   = halt;
  assign bus.mem_ready_i  = rdy;
  assign bus0.halt_req_i  = halt;
  assign bus0.mem_ready_i = rdy;

  fetch_sequencer #(.READY_TIMEOUT(15)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.master)
  );

  fetch_sequencer #(.READY_TIMEOUT(0)) dut0 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus0.master)
  );

  // Small datapath: PC mux code 2 selects reset vector 8'hFF, MAR mux 0 selects PC.
  logic [7:0] pc_q  = 8'h00;
  logic [7:0] mar_q = 8'h00;
  always @(posedge clk) begin
    if (!bus.pc_rst_no)      pc_q <= 8'h00;
    else if (!bus.pc_ld_no)  pc_q <= (bus.pc_src_o == 3'd2) ? 8'hFF : 8'h00;
    else if (!bus.pc_inc_no) pc_q <= pc_q + 8'd1;
    if (!bus.mar_rst_no)     mar_q <= 8'h00;
    else if (!bus.mar_ld_no) mar_q <= (bus.addr_src_o == 2'd0) ? pc_q : 8'h00;
  end

  logic [16:0] act;
  assign act = {bus.pc_rst_no, bus.pc_ld_no, bus.pc_inc_no, bus.mar_rst_no,
                bus.mar_ld_no, bus.ir_ld_no, bus.mem_rd_o, bus.pc_src_o,
                bus.addr_src_o, bus.halted_o, bus.fault_o, bus.state_o};

  typedef struct {
    logic       r, h, m;
    state_e     st;
    bit         chk_pc;
    logic [7:0] pc;
    bit         chk_mar;
    logic [7:0] mar;
  } vec_t;

  typedef struct {
    int          idx;
    logic [16:0] outs;
    bit          chk_pc;
    logic [7:0]  pc;
    bit          chk_mar;
    logic [7:0]  mar;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic void addx(logic r, logic h, logic m, state_e st,
                               bit cp, logic [7:0] pc, bit cm, logic [7:0] mar);
    vec_t v;
    v.r = r; v.h = h; v.m = m; v.st = st;
    v.chk_pc = cp; v.pc = pc; v.chk_mar = cm; v.mar = mar;
    vecs.push_back(v);
  endfunction

  function automatic void add(logic r, logic h, logic m, state_e st);
    addx(r, h, m, st, 1'b0, 8'h00, 1'b0, 8'h00);
  endfunction

  // Reference output decode: {pc_rst,pc_ld,pc_inc,mar_rst,mar_ld,ir_ld,rd,pc_src,addr_src,halted,fault,state}
  function automatic logic [16:0] exp_outs(state_e s, logic m);
    logic       prst, pld, pinc, mrst, mld, irld, rd, hl, ft;
    logic [2:0] psrc;
    logic [1:0] asrc;
    prst = 1'b1; pld = 1'b1; pinc = 1'b1; mrst = 1'b1; mld = 1'b1; irld = 1'b1;
    rd = 1'b0; hl = 1'b0; ft = 1'b0; psrc = 3'd0; asrc = 2'd0;
    case (s)
      S_RESET:      begin prst = 1'b0; mrst = 1'b0; end
      S_VECTOR:     begin pld = 1'b0; psrc = 3'd2; end
      S_FETCH_ADDR: begin mld = 1'b0; asrc = 2'd0; end
      S_FETCH_MEM:  begin rd = 1'b1; if (m) begin irld = 1'b0; pinc = 1'b0; end end
      S_HALT:       hl = 1'b1;
      S_FAULT:      ft = 1'b1;
      default:      ;
    endcase
    return {prst, pld, pinc, mrst, mld, irld, rd, psrc, asrc, hl, ft, s};
  endfunction

  initial begin
    exp_t e;
    bit   dut0_faulted;

    // Power-on reset then 4 checked reset cycles.
    for (int i = 0; i < 4; i++) add(1, 0, 0, S_RESET);
    // Reset release, vector, zero-wait fetch loop with MAR tracking PC.
    for (int i = 0; i < 3; i++) add(0, 0, 1, S_RESET);
    add (0, 0, 1, S_VECTOR);
    addx(0, 0, 1, S_FETCH_ADDR, 1, 8'hFF, 0, 8'h00);
    addx(0, 0, 1, S_FETCH_MEM,  0, 8'h00, 1, 8'hFF);
    add (0, 0, 1, S_DECODE);
    add (0, 0, 1, S_FETCH_ADDR);
    addx(0, 0, 1, S_FETCH_MEM,  0, 8'h00, 1, 8'h00);
    add (0, 0, 1, S_DECODE);
    add (0, 0, 1, S_FETCH_ADDR);
    addx(0, 0, 1, S_FETCH_MEM,  0, 8'h00, 1, 8'h01);
    add (0, 0, 1, S_DECODE);
    // Two wait states then ready.
    add(0, 0, 0, S_FETCH_ADDR);
    add(0, 0, 0, S_FETCH_MEM);
    add(0, 0, 0, S_FETCH_MEM);
    add(0, 0, 1, S_FETCH_MEM);
    add(0, 0, 0, S_DECODE);
    // Halt pulse in FETCH_MEM is lost; pulse in DECODE halts.
    add(0, 0, 0, S_FETCH_ADDR);
    add(0, 1, 1, S_FETCH_MEM);
    add(0, 0, 1, S_DECODE);
    add(0, 0, 0, S_FETCH_ADDR);
    add(0, 0, 1, S_FETCH_MEM);
    add(0, 1, 1, S_DECODE);
    add(0, 0, 1, S_HALT);
    add(0, 1, 0, S_HALT);
    add(0, 0, 1, S_HALT);
    // Reset out of HALT, then reset during FETCH_MEM with ready high.
    add(1, 0, 1, S_HALT);
    for (int i = 0; i < 3; i++) add(0, 0, 1, S_RESET);
    add(0, 0, 1, S_VECTOR);
    add(0, 0, 1, S_FETCH_ADDR);
    add(1, 0, 1, S_FETCH_MEM);
    for (int i = 0; i < 3; i++) add(0, 0, 1, S_RESET);
    add (0, 0, 1, S_VECTOR);
    addx(0, 0, 1, S_FETCH_ADDR, 1, 8'hFF, 0, 8'h00);
    addx(0, 0, 1, S_FETCH_MEM,  0, 8'h00, 1, 8'hFF);
    add (0, 0, 0, S_DECODE);
    // Ready never arrives: 15 FETCH_MEM cycles then FAULT holds.
    add(0, 0, 0, S_FETCH_ADDR);
    for (int i = 0; i < 15; i++) add(0, 0, 0, S_FETCH_MEM);
    add(0, 0, 0, S_FAULT);
    add(0, 1, 1, S_FAULT);
    add(0, 0, 0, S_FAULT);
    // Recover from FAULT through reset.
    add(1, 0, 0, S_FAULT);
    for (int i = 0; i < 3; i++) add(0, 0, 0, S_RESET);
    add(0, 0, 0, S_VECTOR);
    add(0, 0, 0, S_FETCH_ADDR);

    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst  = vecs[i].r;
      halt = vecs[i].h;
      rdy  = vecs[i].m;
      e.idx = i; e.outs = exp_outs(vecs[i].st, vecs[i].m);
      e.chk_pc = vecs[i].chk_pc; e.pc = vecs[i].pc;
      e.chk_mar = vecs[i].chk_mar; e.mar = vecs[i].mar;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (act !== e.outs) begin
        bad++;
        $display("FAIL vec%0d outputs: got %b want %b", e.idx, act, e.outs);
      end
      if (e.chk_pc) begin
        total++;
        if (pc_q !== e.pc) begin
          bad++;
          $display("FAIL vec%0d pc: got %h want %h", e.idx, pc_q, e.pc);
        end
      end
      if (e.chk_mar) begin
        total++;
        if (mar_q !== e.mar) begin
          bad++;
          $display("FAIL vec%0d mar: got %h want %h", e.idx, mar_q, e.mar);
        end
      end
    end

    // Timeout disabled: dut0 waits indefinitely while dut faults again.
    dut0_faulted = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; halt = 1'b0; rdy = 1'b0;
      @(negedge clk);
      if (bus0.fault_o) dut0_faulted = 1'b1;
    end
    total++;
    if (dut0_faulted !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout_fault: got %b want 0", dut0_faulted);
    end
    total++;
    if (bus0.state_o !== 3'd3) begin
      bad++;
      $display("FAIL no_timeout_state: got %0d want 3", bus0.state_o);
    end
    total++;
    if (bus.fault_o !== 1'b1 || bus.state_o !== 3'd6) begin
      bad++;
      $display("FAIL timeout_refault: got fault=%b state=%0d want fault=1 state=6",
               bus.fault_o, bus.state_o);
    end

    // Ready arriving after a long wait still completes the fetch on dut0.
    @(posedge clk); #1;
    rdy = 1'b1;
    @(negedge clk);
    total++;
    if (bus0.ir_ld_no !== 1'b0 || bus0.pc_inc_no !== 1'b0 || bus0.mem_rd_o !== 1'b1) begin
      bad++;
      $display("FAIL late_ready: got ir=%b inc=%b rd=%b want ir=0 inc=0 rd=1",
               bus0.ir_ld_no, bus0.pc_inc_no, bus0.mem_rd_o);
    end
    @(posedge clk); #1;
    rdy = 1'b0;
    @(negedge clk);
    total++;
    if (bus0.state_o !== 3'd4) begin
      bad++;
      $display("FAIL late_ready_decode: got %0d want 4", bus0.state_o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
